// File: rtl/opnd_fetch_pkg.sv
// opnd_fetch_pkg -- shared types and defaults for the operand-fetch stage.
//   state_t   : fetch FSM states (IDLE, CHK, OUT)
//   XLEN_DEF  : default register width
//   NREGS_DEF : default register count
package opnd_fetch_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHK  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/opnd_fetch_scoreboard.sv
// opnd_scoreboard -- pending-write scoreboard, one bit per architectural reg.
//   clk, rst_n            : clock, async active-low reset (clears all bits)
//   set_en/set_addr       : mark a register as having a write in flight
//   clr0_*/clr1_*         : writeback clears (two ports)
//   look_a/b_addr, pend_* : combinational lookup of the current bits
// A set and a clear on the same bit in the same cycle leaves the bit set.
module opnd_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr0_en,
    input  logic [AW-1:0] clr0_addr,
    input  logic          clr1_en,
    input  logic [AW-1:0] clr1_addr,
    input  logic [AW-1:0] look_a_addr,
    input  logic [AW-1:0] look_b_addr,
    output logic          pend_a,
    output logic          pend_b
);

    logic [NREGS-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr0_en) sb_d[clr0_addr] = 1'b0;
        if (clr1_en) sb_d[clr1_addr] = 1'b0;
        // Applied last so a same-cycle set beats either clear.
        if (set_en)  sb_d[set_addr]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign pend_a = sb_q[look_a_addr];
    assign pend_b = sb_q[look_b_addr];

endmodule

// File: rtl/opnd_fetch.sv
// opnd_fetch -- operand fetch stage with pending-write scoreboard.
// Accepts one instruction (ra/rb/rt + use flags), waits in CHK until no used
// source has a write in flight, reads the register file (data one cycle
// later), then presents operands on out_*. Writeback ports are forwarded
// straight to the register file write ports and clear scoreboard bits.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready, in_ra/rb/rt,
//   in_use_a/use_b/wr                : instruction input handshake
//   rf_readEn0/1, rf_readAddr0/1,
//   rf_readData0/1                   : register-file read ports
//   wb0_*/wb1_*                      : writeback inputs
//   rf_writeEn0/1, rf_writeAddr0/1,
//   rf_writeData0/1                  : register-file write ports (pass-through)
//   out_valid/out_ready, out_a/b,
//   out_rt, out_wr                   : operand output handshake
// Build option: OPND_FETCH_BYPASS_EN lets a same-cycle writeback satisfy a
// source in CHK and forwards its data in place of the stale read data.
module opnd_fetch
    import opnd_fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_ra,
    input  logic [AW-1:0]   in_rb,
    input  logic [AW-1:0]   in_rt,
    input  logic            in_use_a,
    input  logic            in_use_b,
    input  logic            in_wr,
    output logic            rf_readEn0,
    output logic [AW-1:0]   rf_readAddr0,
    input  logic [XLEN-1:0] rf_readData0,
    output logic            rf_readEn1,
    output logic [AW-1:0]   rf_readAddr1,
    input  logic [XLEN-1:0] rf_readData1,
    input  logic            wb0_en,
    input  logic [AW-1:0]   wb0_addr,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_en,
    input  logic [AW-1:0]   wb1_addr,
    input  logic [XLEN-1:0] wb1_data,
    output logic            rf_writeEn0,
    output logic [AW-1:0]   rf_writeAddr0,
    output logic [XLEN-1:0] rf_writeData0,
    output logic            rf_writeEn1,
    output logic [AW-1:0]   rf_writeAddr1,
    output logic [XLEN-1:0] rf_writeData1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [AW-1:0]   out_rt,
    output logic            out_wr
);

    state_t        state_q, state_d;
    logic [AW-1:0] ra_q, ra_d, rb_q, rb_d, rt_q, rt_d;
    logic          use_a_q, use_a_d, use_b_q, use_b_d, wr_q, wr_d;

    logic          pend_a, pend_b;
    logic          ready_a, ready_b, hazard;
    logic          sb_set;

    // Register-file writes are a straight pass-through; with both ports on
    // the same address the file itself keeps the wb1 value.
    assign rf_writeEn0   = wb0_en;
    assign rf_writeAddr0 = wb0_addr;
    assign rf_writeData0 = wb0_data;
    assign rf_writeEn1   = wb1_en;
    assign rf_writeAddr1 = wb1_addr;
    assign rf_writeData1 = wb1_data;

    opnd_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (sb_set),
        .set_addr    (rt_q),
        .clr0_en     (wb0_en),
        .clr0_addr   (wb0_addr),
        .clr1_en     (wb1_en),
        .clr1_addr   (wb1_addr),
        .look_a_addr (ra_q),
        .look_b_addr (rb_q),
        .pend_a      (pend_a),
        .pend_b      (pend_b)
    );

`ifdef OPND_FETCH_BYPASS_EN
    // A writeback landing this cycle makes the source ready; wb1 data wins
    // when both ports hit the same register.
    logic            hit_a, hit_b;
    logic [XLEN-1:0] hit_a_data, hit_b_data;
    logic            byp_a_q, byp_a_d, byp_b_q, byp_b_d;
    logic [XLEN-1:0] byp_a_data_q, byp_a_data_d, byp_b_data_q, byp_b_data_d;

    assign hit_a      = (wb0_en && wb0_addr == ra_q) || (wb1_en && wb1_addr == ra_q);
    assign hit_b      = (wb0_en && wb0_addr == rb_q) || (wb1_en && wb1_addr == rb_q);
    assign hit_a_data = (wb1_en && wb1_addr == ra_q) ? wb1_data : wb0_data;
    assign hit_b_data = (wb1_en && wb1_addr == rb_q) ? wb1_data : wb0_data;
    assign ready_a    = !use_a_q || !pend_a || hit_a;
    assign ready_b    = !use_b_q || !pend_b || hit_b;
`else
    assign ready_a    = !use_a_q || !pend_a;
    assign ready_b    = !use_b_q || !pend_b;
`endif
    assign hazard = !(ready_a && ready_b);

    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        rt_d         = rt_q;
        use_a_d      = use_a_q;
        use_b_d      = use_b_q;
        wr_d         = wr_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        rf_readEn0   = 1'b0;
        rf_readEn1   = 1'b0;
        rf_readAddr0 = ra_q;
        rf_readAddr1 = rb_q;
        sb_set       = 1'b0;
`ifdef OPND_FETCH_BYPASS_EN
        byp_a_d      = byp_a_q;
        byp_b_d      = byp_b_q;
        byp_a_data_d = byp_a_data_q;
        byp_b_data_d = byp_b_data_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ra_d    = in_ra;
                    rb_d    = in_rb;
                    rt_d    = in_rt;
                    use_a_d = in_use_a;
                    use_b_d = in_use_b;
                    wr_d    = in_wr;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (!hazard) begin
                    rf_readEn0 = use_a_q;
                    rf_readEn1 = use_b_q;
                    state_d    = OUT;
`ifdef OPND_FETCH_BYPASS_EN
                    // The file returns pre-write data for a same-cycle
                    // write, so capture the writeback value here.
                    byp_a_d      = use_a_q && hit_a;
                    byp_b_d      = use_b_q && hit_b;
                    byp_a_data_d = hit_a_data;
                    byp_b_data_d = hit_b_data;
`endif
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sb_set  = wr_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to zero outside OUT; in OUT the read data is held
    // by the file because no read is issued there.
    always_comb begin
        out_a  = '0;
        out_b  = '0;
        out_rt = '0;
        out_wr = 1'b0;
        if (state_q == OUT) begin
            out_rt = rt_q;
            out_wr = wr_q;
`ifdef OPND_FETCH_BYPASS_EN
            if (use_a_q) out_a = byp_a_q ? byp_a_data_q : rf_readData0;
            if (use_b_q) out_b = byp_b_q ? byp_b_data_q : rf_readData1;
`else
            if (use_a_q) out_a = rf_readData0;
            if (use_b_q) out_b = rf_readData1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rt_q    <= '0;
            use_a_q <= 1'b0;
            use_b_q <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rt_q    <= rt_d;
            use_a_q <= use_a_d;
            use_b_q <= use_b_d;
            wr_q    <= wr_d;
        end
    end

`ifdef OPND_FETCH_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_a_q      <= 1'b0;
            byp_b_q      <= 1'b0;
            byp_a_data_q <= '0;
            byp_b_data_q <= '0;
        end else begin
            byp_a_q      <= byp_a_d;
            byp_b_q      <= byp_b_d;
            byp_a_data_q <= byp_a_data_d;
            byp_b_data_q <= byp_b_data_d;
        end
    end
`endif

endmodule
